reg_xfer_fsm: RTL and testbench

Parametrised register-transfer sequencer for the microcontroller's general-register file. It decodes a 16-bit instruction, `{opcode[15:12], dst[11:6], src[5:0]}`, and drives one-hot read (`rx_out`) and write (`rx_in`) selects plus a PC-increment strobe. It executes MOV (dst ← src), and optionally SWAP through a temporary register. It sits beside the other per-opcode FSMs, and the control unit ORs the select and strobe outputs of all of them.

---
 rtl/reg_xfer_fsm.sv | 169 ++++++++++++++++
 tb/tb_reg_xfer_fsm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_fsm.sv
// Register-transfer sequencer: decodes MOV (and SWAP when REG_XFER_SWAP_EN is
// defined) and drives one-hot register read/write selects plus a PC strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | opcode not handled here, all outputs 0
// FETCH | pc increment, source read select, index validity check
// XFER  | MOV: dst <- src
// SW_T  | SWAP: tmp <- src
// SW_A  | SWAP: src <- dst
// SW_B  | SWAP: dst <- tmp
// DONE  | completion pulse, err when an index was out of range
// HOLD  | parked until opcode changes or a new instruction is loaded
module reg_xfer_fsm #(
  parameter int          NUM_REGS = 6,
  parameter logic [3:0]  MOV_OP   = 4'b0100,
  parameter logic [3:0]  SWAP_OP  = 4'b0101
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         instruction,
  input  logic                instr_valid,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in,
  output logic                tmp_out,
  output logic                tmp_in,
  output logic                pc_inc,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    XFER  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
`ifdef REG_XFER_SWAP_EN
    ,
    SW_T  = 3'd5,
    SW_A  = 3'd6,
    SW_B  = 3'd7
`endif
  } state_t;

  state_t     state;
  logic       err_flag;
  logic [3:0] opcode;
  logic [5:0] dst;
  logic [5:0] src;
  logic       mov_hit;
  logic       swap_hit;
  logic       op_ok;
  logic       idx_ok;

  assign opcode = instruction[15:12];
  assign dst    = instruction[11:6];
  assign src    = instruction[5:0];

  // Index k selects bit NUM_REGS-1-k; out-of-range indices give all zeros.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [5:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == 6'(k)) v[NUM_REGS-1-k] = 1'b1;
    end
    return v;
  endfunction

  assign mov_hit = (opcode == MOV_OP);
`ifdef REG_XFER_SWAP_EN
  assign swap_hit = (opcode == SWAP_OP);
`else
  logic unused_swap_op;
  assign unused_swap_op = ^SWAP_OP;
  assign swap_hit       = 1'b0;
`endif
  assign op_ok  = mov_hit | swap_hit;
  assign idx_ok = ({26'd0, src} < 32'(NUM_REGS)) && ({26'd0, dst} < 32'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_flag <= 1'b0;
    end else if (!op_ok) begin
      state    <= IDLE;
    end else if (instr_valid) begin
      state    <= FETCH;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          err_flag <= 1'b0;
        end
        FETCH: begin
          if (!idx_ok) begin
            state    <= DONE;
            err_flag <= 1'b1;
          end else if (mov_hit) begin
            state <= XFER;
          end else begin
`ifdef REG_XFER_SWAP_EN
            state <= SW_T;
`else
            state <= IDLE;
`endif
          end
        end
        XFER:    state <= DONE;
`ifdef REG_XFER_SWAP_EN
        SW_T:    state <= SW_A;
        SW_A:    state <= SW_B;
        SW_B:    state <= DONE;
`endif
        DONE:    state <= HOLD;
        HOLD:    state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rx_out  = '0;
    rx_in   = '0;
    tmp_out = 1'b0;
    tmp_in  = 1'b0;
    pc_inc  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state)
      FETCH: begin
        pc_inc = 1'b1;
        rx_out = onehot(src);
        busy   = 1'b1;
      end
      XFER: begin
        rx_out = onehot(src);
        rx_in  = onehot(dst);
        busy   = 1'b1;
      end
`ifdef REG_XFER_SWAP_EN
      SW_T: begin
        rx_out = onehot(src);
        tmp_in = 1'b1;
        busy   = 1'b1;
      end
      SW_A: begin
        rx_out = onehot(dst);
        rx_in  = onehot(src);
        busy   = 1'b1;
      end
      SW_B: begin
        tmp_out = 1'b1;
        rx_in   = onehot(dst);
        busy    = 1'b1;
      end
`endif
      DONE: begin
        done = 1'b1;
        err  = err_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_xfer_fsm.sv
// Directed vector bench for reg_xfer_fsm with NUM_REGS=6; swap rows follow
// REG_XFER_SWAP_EN.
module tb_reg_xfer_fsm;

  logic        clk;
  logic        rst_n;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [5:0]  rx_out;
  logic [5:0]  rx_in;
  logic        tmp_out;
  logic        tmp_in;
  logic        pc_inc;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  reg_xfer_fsm #(.NUM_REGS(6), .MOV_OP(4'b0100), .SWAP_OP(4'b0101)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .rx_out(rx_out), .rx_in(rx_in), .tmp_out(tmp_out), .tmp_in(tmp_in),
    .pc_inc(pc_inc), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // {rx_out, rx_in, tmp_out, tmp_in, pc_inc, busy, done, err}
  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic [17:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] o(input logic [5:0] ro, input logic [5:0] ri,
                                    input logic to, input logic ti, input logic pc,
                                    input logic bz, input logic dn, input logic er);
    return {ro, ri, to, ti, pc, bz, dn, er};
  endfunction

  function automatic void add(input logic [15:0] i, input logic v,
                              input logic [17:0] e, input string n);
    vec_t t;
    t.instr = i; t.valid = v; t.exp = e; t.name = n;
    vecs.push_back(t);
  endfunction

  task automatic check(input string n, input logic [17:0] e);
    logic [17:0] act;
    act = {rx_out, rx_in, tmp_out, tmp_in, pc_inc, busy, done, err};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b", n, act, e);
    end
  endtask

  localparam logic [17:0] ZERO = 18'd0;

  initial begin
    // MOV dst=1 src=2
    add(16'h4042, 1'b0, o(6'b001000, 6'b000000, 0, 0, 1, 1, 0, 0), "mov_fetch");
    add(16'h4042, 1'b0, o(6'b001000, 6'b010000, 0, 0, 0, 1, 0, 0), "mov_xfer");
    add(16'h4042, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 0), "mov_done");
    add(16'h4042, 1'b0, ZERO, "mov_hold1");
    add(16'h4042, 1'b0, ZERO, "mov_hold2");
    add(16'h4042, 1'b1, o(6'b001000, 6'b000000, 0, 0, 1, 1, 0, 0), "hold_restart_fetch");
    add(16'h4042, 1'b0, o(6'b001000, 6'b010000, 0, 0, 0, 1, 0, 0), "hold_restart_xfer");
    add(16'h4042, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 0), "hold_restart_done");
    add(16'h4042, 1'b0, ZERO, "hold_restart_hold");
    // invalid src=7
    add(16'h4007, 1'b1, o(6'b000000, 6'b000000, 0, 0, 1, 1, 0, 0), "badsrc_fetch");
    add(16'h4007, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 1), "badsrc_done");
    add(16'h4007, 1'b0, ZERO, "badsrc_hold");
    // invalid dst=6 (== NUM_REGS), src=5
    add(16'h4185, 1'b1, o(6'b000001, 6'b000000, 0, 0, 1, 1, 0, 0), "baddst_fetch");
    add(16'h4185, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 1), "baddst_done");
    add(16'h4185, 1'b0, ZERO, "baddst_hold");
    // boundary valid indices dst=0 src=5
    add(16'h4005, 1'b1, o(6'b000001, 6'b000000, 0, 0, 1, 1, 0, 0), "edge_fetch");
    add(16'h4005, 1'b0, o(6'b000001, 6'b100000, 0, 0, 0, 1, 0, 0), "edge_xfer");
    add(16'h4005, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 0), "edge_done");
    // foreign opcode wins over instr_valid
    add(16'h0042, 1'b0, ZERO, "op0_idle");
    add(16'h0042, 1'b1, ZERO, "op0_valid_idle");
    // IDLE -> FETCH, then restart during XFER with 4081 (dst=2 src=1)
    add(16'h4042, 1'b0, o(6'b001000, 6'b000000, 0, 0, 1, 1, 0, 0), "idle_fetch");
    add(16'h4042, 1'b0, o(6'b001000, 6'b010000, 0, 0, 0, 1, 0, 0), "pre_abort_xfer");
    add(16'h4081, 1'b1, o(6'b010000, 6'b000000, 0, 0, 1, 1, 0, 0), "abort_fetch");
    add(16'h4081, 1'b0, o(6'b010000, 6'b001000, 0, 0, 0, 1, 0, 0), "abort_xfer");
    add(16'h4081, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 0), "abort_done");
    add(16'h4081, 1'b0, ZERO, "abort_hold");
`ifdef REG_XFER_SWAP_EN
    // SWAP dst=0 src=3
    add(16'h5003, 1'b1, o(6'b000100, 6'b000000, 0, 0, 1, 1, 0, 0), "swap_fetch");
    add(16'h5003, 1'b0, o(6'b000100, 6'b000000, 0, 1, 0, 1, 0, 0), "swap_t");
    add(16'h5003, 1'b0, o(6'b100000, 6'b000100, 0, 0, 0, 1, 0, 0), "swap_a");
    add(16'h5003, 1'b0, o(6'b000000, 6'b100000, 1, 0, 0, 1, 0, 0), "swap_b");
    add(16'h5003, 1'b0, o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 0), "swap_done");
    add(16'h5003, 1'b0, ZERO, "swap_hold");
    add(16'h5003, 1'b1, o(6'b000100, 6'b000000, 0, 0, 1, 1, 0, 0), "swap2_fetch");
    add(16'h5003, 1'b0, o(6'b000100, 6'b000000, 0, 1, 0, 1, 0, 0), "swap2_t");
    add(16'h5003, 1'b0, o(6'b100000, 6'b000100, 0, 0, 0, 1, 0, 0), "swap2_a");
    add(16'h0003, 1'b0, ZERO, "swap2_opchange_idle");
`else
    add(16'h5003, 1'b0, ZERO, "noswap_idle");
    add(16'h5003, 1'b1, ZERO, "noswap_valid_idle");
    add(16'h5003, 1'b0, ZERO, "noswap_idle2");
`endif

    rst_n = 1'b0;
    instruction = 16'h4042;
    instr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("reset_hold", ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      instruction = vecs[i].instr;
      instr_valid = vecs[i].valid;
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // asynchronous reset mid-sequence clears state and the error flag
    instruction = 16'h4007;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_seq_fetch", o(6'b000000, 6'b000000, 0, 0, 1, 1, 0, 0));
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_seq_done_err", o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 1));
    #2 rst_n = 1'b0;
    #1 check("rst_async_zero", ZERO);
    @(posedge clk); #1;
    check("rst_async_hold", ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    instruction = 16'h4042;
    @(posedge clk); #1;
    check("post_rst_fetch", o(6'b001000, 6'b000000, 0, 0, 1, 1, 0, 0));
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check("rst_in_xfer_zero", ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst2_fetch", o(6'b001000, 6'b000000, 0, 0, 1, 1, 0, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_rst2_done_noerr", o(6'b000000, 6'b000000, 0, 0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
